// File: rtl/framebuffer_stream_reader.sv
// rtl/framebuffer_stream_reader.sv - drains one framebuffer frame from BRAM as an 8-bit pixel stream
//
// Purpose: on frame_ready, reads WORDS_PER_FRAME words from the read-side BRAM
// port through a 2-entry word FIFO and unpacks each word into 8 pixels,
// most significant byte first, with valid/ready flow control.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   frame_ready              one-cycle pulse: a completed frame is available
//   bram_addr, bram_we       BRAM read address (0 when idle), write enable (always 0)
//   bram_data_out            BRAM read data, valid one cycle after the address
//   m_data, m_valid, m_ready pixel stream handshake
//   m_last                   last pixel of an image line
//   m_user                   first pixel of the frame
//   busy                     frame transfer in progress
//   frame_done               one-cycle pulse after the final pixel is accepted
//   overrun                  one-cycle pulse when frame_ready arrives while not idle
module framebuffer_stream_reader #(
    parameter int ADDR_WIDTH      = 14,
    parameter int DATA_WIDTH_BRAM = 64,
    parameter int WORDS_PER_FRAME = 9600,
    parameter int WORDS_PER_LINE  = 40
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_ready,
    output logic [ADDR_WIDTH-1:0]      bram_addr,
    output logic                       bram_we,
    input  logic [DATA_WIDTH_BRAM-1:0] bram_data_out,
    output logic [7:0]                 m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_last,
    output logic                       m_user,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int PIX_PER_LINE = 8 * WORDS_PER_LINE;
    localparam int COL_W        = $clog2(PIX_PER_LINE);
    localparam int POP_W        = $clog2(WORDS_PER_FRAME + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS_PER_FRAME - 1);
    localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(PIX_PER_LINE - 1);
    localparam logic [POP_W-1:0]      LAST_POP  = POP_W'(WORDS_PER_FRAME - 1);

    logic [1:0]                 state;
    logic [ADDR_WIDTH-1:0]      rd_cnt;
    logic                       rd_pending;
    logic [DATA_WIDTH_BRAM-1:0] fifo_mem [0:1];
    logic                       wr_ptr;
    logic                       rd_ptr;
    logic [1:0]                 fifo_cnt;
    logic [2:0]                 byte_idx;
    logic [COL_W-1:0]           col;
    logic [POP_W-1:0]           pop_cnt;
    logic                       first_pix;
    logic                       overrun_q;

    logic                       issue;
    logic                       xfer;
    logic                       pop;
    logic [DATA_WIDTH_BRAM-1:0] head;
    logic [7:0]                 pix;

    // Occupancy counts the word whose read data is on the bus this cycle, so
    // the FIFO can never be asked to hold more than its two entries.
    assign issue = (state == S_FETCH) &&
                   (({1'b0, fifo_cnt} + {2'b00, rd_pending}) < 3'd2);

    assign head = fifo_mem[rd_ptr];
    assign xfer = m_valid && m_ready;
    assign pop  = xfer && (byte_idx == 3'd7);

    always_comb begin
        pix = 8'd0;
        for (int b = 0; b < 8; b++) begin
            if (byte_idx == 3'(b)) begin
                pix = head[DATA_WIDTH_BRAM-1-8*b -: 8];
            end
        end
    end

    assign m_valid    = (fifo_cnt != 2'd0);
    assign m_data     = m_valid ? pix : 8'd0;
    assign m_last     = m_valid && (col == LAST_COL);
    assign m_user     = m_valid && first_pix;
    assign bram_addr  = issue ? rd_cnt : '0;
    assign bram_we    = 1'b0;
    assign busy       = (state == S_FETCH) || (state == S_DRAIN);
    assign frame_done = (state == S_DONE);
    assign overrun    = overrun_q;

    // Storage only; validity is tracked by fifo_cnt, so no reset needed.
    always_ff @(posedge clk) begin
        if (rd_pending) begin
            fifo_mem[wr_ptr] <= bram_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rd_cnt     <= '0;
            rd_pending <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_cnt   <= 2'd0;
            byte_idx   <= 3'd0;
            col        <= '0;
            pop_cnt    <= '0;
            first_pix  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q  <= frame_ready && (state != S_IDLE);
            rd_pending <= issue;

            unique case (state)
                S_IDLE: begin
                    if (frame_ready) begin
                        state     <= S_FETCH;
                        rd_cnt    <= '0;
                        pop_cnt   <= '0;
                        col       <= '0;
                        first_pix <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (issue && (rd_cnt == LAST_ADDR)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && (pop_cnt == LAST_POP)) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Counter parks on the last address instead of wrapping.
            if (issue && (rd_cnt != LAST_ADDR)) begin
                rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
            end

            if (rd_pending) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                pop_cnt <= pop_cnt + POP_W'(1);
            end

            unique case ({rd_pending, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            // byte_idx wraps 7 -> 0 on its own, in step with the pop.
            if (xfer) begin
                byte_idx  <= byte_idx + 3'd1;
                col       <= (col == LAST_COL) ? '0 : col + COL_W'(1);
                first_pix <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_framebuffer_stream_reader.sv
// tb/tb_framebuffer_stream_reader.sv - self-checking bench for framebuffer_stream_reader
module tb_framebuffer_stream_reader;

    localparam int AW   = 14;
    localparam int DW   = 64;
    localparam int WPF  = 4;
    localparam int WPL  = 2;
    localparam int NPIX = 8 * WPF;
    localparam int PPL  = 8 * WPL;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_ready;
    logic [AW-1:0] bram_addr;
    logic          bram_we;
    logic [DW-1:0] bram_q;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          m_user;
    logic          busy;
    logic          frame_done;
    logic          overrun;

    framebuffer_stream_reader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH_BRAM(DW),
        .WORDS_PER_FRAME(WPF),
        .WORDS_PER_LINE(WPL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_ready(frame_ready),
        .bram_addr(bram_addr),
        .bram_we(bram_we),
        .bram_data_out(bram_q),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_last(m_last),
        .m_user(m_user),
        .busy(busy),
        .frame_done(frame_done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;      // 0 ready high, 1 random, 2 alternating
        int pulse_at;  // beat count at which frame_ready is re-pulsed, -1 none
        int exp_done;  // frame_done cycle relative to frame_ready, -1 unchecked
        int exp_ovr;   // expected overrun pulses
    } vec_t;

    vec_t vecs [5];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    int beats, lasts, users, done_cnt, ovr_cnt, done_rel, ovr_rel, first_valid_rel;
    int frame_beats;
    int mrel;
    logic       mon_en = 1'b0;
    logic       stall_prev = 1'b0;
    logic [9:0] prev_beat;
    logic [9:0] exp_q [$];
    logic [9:0] e;

    function automatic logic [63:0] word_of(int a);
        logic [63:0] w;
        w = '0;
        for (int b = 0; b < 8; b++) begin
            w[63-8*b -: 8] = 8'(8 * a + b);
        end
        return w;
    endfunction

    always @(posedge clk) bram_q <= word_of(int'(bram_addr));

    function automatic void chk(string nm, longint act, longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endfunction

    function automatic void push_frame();
        logic [7:0] d;
        logic       lst;
        logic       usr;
        for (int k = 0; k < NPIX; k++) begin
            d   = 8'(k);
            lst = ((k % PPL) == PPL - 1);
            usr = (k == 0);
            exp_q.push_back({d, lst, usr});
        end
    endfunction

    function automatic logic ready_for(int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return 1'(cyc % 2);
    endfunction

    task automatic clear_counts();
        beats = 0; lasts = 0; users = 0; done_cnt = 0; ovr_cnt = 0;
        done_rel = -1; ovr_rel = -1; first_valid_rel = -1; frame_beats = 0;
    endtask

    // Caller is positioned just after a rising edge; that cycle becomes cycle 0.
    task automatic pulse_start();
        frame_ready = 1'b1;
        t0 = cyc;
        push_frame();
        @(negedge clk);
        chk("busy_cycle0", busy, 0);
        @(posedge clk);
        #1 frame_ready = 1'b0;
        @(negedge clk);
        chk("busy_cycle1", busy, 1);
    endtask

    task automatic wait_done(int n, int budget);
        for (int c = 0; c < budget && done_cnt < n; c++) begin
            @(posedge clk);
            #1;
        end
        if (done_cnt < n) chk("timeout_frame_done", done_cnt, n);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: scoreboard pop on each transfer, stall stability, read bounds.
    initial begin
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                stall_prev  = 1'b0;
                frame_beats = 0;
            end else begin
                mrel = cyc - t0;
                chk("bram_we", bram_we, 0);
                if (bram_addr != '0) begin
                    chk("addr_in_range", int'(bram_addr) < WPF, 1);
                    chk("outstanding_le2", (int'(bram_addr) + 1 - frame_beats / 8) <= 2, 1);
                end
                if (stall_prev) begin
                    chk("stall_valid", m_valid, 1);
                    chk("stall_hold", {m_data, m_last, m_user}, prev_beat);
                end
                if (m_valid && first_valid_rel < 0) first_valid_rel = mrel;
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", beats, -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data_last_user", {m_data, m_last, m_user}, e);
                    end
                    beats++;
                    frame_beats++;
                    if (m_last) lasts++;
                    if (m_user) users++;
                end
                stall_prev = m_valid && !m_ready;
                prev_beat  = {m_data, m_last, m_user};
                if (frame_done) begin
                    done_cnt++;
                    done_rel = mrel;
                    chk("busy_low_at_done", busy, 0);
                    frame_beats = 0;
                end
                if (overrun) begin
                    ovr_cnt++;
                    ovr_rel = mrel;
                end
            end
        end
    end

    task automatic run_vec(vec_t v);
        logic pulsed;
        int   prel;
        pulsed = 1'b0;
        prel   = -1;
        clear_counts();
        @(posedge clk);
        #1 m_ready = ready_for(v.mode);
        pulse_start();
        for (int c = 0; c < 2000 && done_cnt == 0; c++) begin
            @(posedge clk);
            #1;
            m_ready     = ready_for(v.mode);
            frame_ready = 1'b0;
            if (v.pulse_at >= 0 && !pulsed && beats >= v.pulse_at) begin
                frame_ready = 1'b1;
                pulsed      = 1'b1;
                prel        = cyc - t0;
            end
        end
        frame_ready = 1'b0;
        if (done_cnt == 0) chk("timeout_frame_done", done_cnt, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("frame_beats", beats, NPIX);
        chk("frame_lasts", lasts, NPIX / PPL);
        chk("frame_users", users, 1);
        chk("frame_done_count", done_cnt, 1);
        chk("first_valid_cycle", first_valid_rel, 3);
        if (v.exp_done >= 0) chk("frame_done_cycle", done_rel, v.exp_done);
        chk("overrun_count", ovr_cnt, v.exp_ovr);
        if (v.pulse_at >= 0) chk("overrun_cycle", ovr_rel, prel + 1);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("busy_after_frame", busy, 0);
    endtask

    int b_at;

    initial begin
        vecs[0] = '{mode: 0, pulse_at: -1, exp_done: 3 + NPIX, exp_ovr: 0};
        vecs[1] = '{mode: 1, pulse_at: -1, exp_done: -1,       exp_ovr: 0};
        vecs[2] = '{mode: 2, pulse_at: -1, exp_done: -1,       exp_ovr: 0};
        vecs[3] = '{mode: 0, pulse_at: 20, exp_done: 3 + NPIX, exp_ovr: 1};
        vecs[4] = '{mode: 1, pulse_at: 10, exp_done: -1,       exp_ovr: 1};

        rst = 1'b1;
        frame_ready = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {bram_addr, bram_we, m_valid, m_data, m_last, m_user,
                              busy, frame_done, overrun}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", {bram_addr, bram_we, m_valid, m_data, m_last, m_user,
                             busy, frame_done, overrun}, 0);
        mon_en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Reset mid-frame, then restart from address 0.
        clear_counts();
        @(posedge clk);
        #1 m_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 200 && beats < 12; c++) begin
            @(posedge clk);
            #1;
        end
        chk("reached_pixel_12", beats >= 12, 1);
        m_ready = 1'b0;
        rst = 1'b1;
        b_at = beats;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_reset_outputs", {bram_addr, bram_we, m_valid, m_data, m_last, m_user,
                                  busy, frame_done, overrun}, 0);
        exp_q.delete();
        m_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("no_beats_after_reset", beats, b_at);
        chk("no_done_after_reset", done_cnt, 0);
        pulse_start();
        wait_done(1, 200);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("restart_beats", beats - b_at, NPIX);
        chk("restart_users", users, 2);
        chk("restart_done_cycle", done_rel, 3 + NPIX);
        chk("restart_scoreboard_empty", exp_q.size(), 0);

        // Back-to-back frames: second frame_ready one cycle after frame_done.
        clear_counts();
        @(posedge clk);
        #1 m_ready = 1'b1;
        pulse_start();
        wait_done(1, 200);
        pulse_start();
        wait_done(2, 200);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("b2b_beats", beats, 2 * NPIX);
        chk("b2b_lasts", lasts, 2 * NPIX / PPL);
        chk("b2b_users", users, 2);
        chk("b2b_done_count", done_cnt, 2);
        chk("b2b_second_done_cycle", done_rel, 3 + NPIX);
        chk("b2b_overrun", ovr_cnt, 0);
        chk("b2b_scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/framebuffer_stream_reader.md
# framebuffer_stream_reader

Drains one completed, normalized frame from the double-buffered framebuffer's BRAM read port and emits it as an 8-bit pixel stream with valid/ready flow control, line-end and frame-start markers. Sits directly downstream of the framebuffer writer. Its frame-done pulse triggers a read, and this block drives that writer's `bram_addr` and `bram_we` inputs and consumes `bram_data_out`. Output feeds the display or DMA stage.

## Interface
- `ADDR_WIDTH`, 14: BRAM word address width.
- `DATA_WIDTH_BRAM`, 64: BRAM word width; 8 pixels per word.
- `WORDS_PER_FRAME`, 9600: words per frame (320x240 / 8).
- `WORDS_PER_LINE`, 40: words per image line (320 / 8).

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `frame_ready`  in  1  one-cycle pulse: a new frame is complete in the read-side buffer. Connect to the writer's done pulse.
- `bram_addr`  out  ADDR_WIDTH  read word address.
- `bram_we`  out  1  constant 0; this block never writes.
- `bram_data_out`  in  DATA_WIDTH_BRAM  read data, valid 1 cycle after address.
- `m_data`  out  8  pixel.
- `m_valid`  out  1  pixel valid.
- `m_ready`  in  1  sink accepts; beat transfers when `m_valid && m_ready`.
- `m_last`  out  1  last pixel of a line; qualified by `m_valid`.
- `m_user`  out  1  first pixel of the frame; qualified by `m_valid`.
- `busy`  out  1  frame transfer in progress.
- `frame_done`  out  1  one-cycle pulse after the final pixel is accepted.
- `overrun`  out  1  one-cycle pulse when `frame_ready` arrives while busy.

## Operation
- States:
  - IDLE: waits for `frame_ready`, then goes to FETCH.
  - FETCH: issues reads until `WORDS_PER_FRAME` words have been requested, then goes to DRAIN.
  - DRAIN: waits until the last pixel is accepted, then goes to DONE.
  - DONE: lasts one cycle, asserts `frame_done`, then returns to IDLE.
- Read issue:
  - A read is issued in a cycle when in FETCH and (FIFO occupancy + in-flight reads) < 2.
  - `bram_addr` takes the read counter in that cycle.
  - The read counter increments per issue, from 0 to `WORDS_PER_FRAME`-1, and never wraps within a frame.
- Word FIFO:
  - 2 entries of `DATA_WIDTH_BRAM`.
  - Written on the cycle after each issue with `bram_data_out`.
  - Never overflows, by the issue rule above.
- Unpacker:
  - Byte index 0..7 into the FIFO head.
  - `m_data` = head[63-8*idx -: 8]; byte [63:56] is the first pixel.
  - `m_valid` = FIFO not empty.
  - On a transfer, idx increments. At idx 7 the head pops and idx returns to 0.
- Markers:
  - A pixel column counter runs 0..8*`WORDS_PER_LINE`-1.
  - `m_last` is high when the column is at its maximum.
  - `m_user` is high only for pixel 0 of the frame.
- Output stability:
  - While `m_valid && !m_ready`, `m_data`, `m_last` and `m_user` hold stable.
  - Pixels are never dropped or duplicated.
- `busy`:
  - Rises on the cycle after `frame_ready` is sampled.
  - Falls in the same cycle `frame_done` is asserted.
- `frame_ready` while busy or in DONE:
  - Ignored.
  - `overrun` pulses on the next cycle.
  - The current transfer continues unaffected.
- `bram_addr` is 0 whenever no read is issued.

## Timing
- Reset values: `bram_addr`=0, `bram_we`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `m_user`=0, `busy`=0, `frame_done`=0, `overrun`=0. Reset also sets the state to IDLE, empties the FIFO, and clears all counters.
- `rst` mid-frame: all outputs return to reset values on the next cycle, and any in-flight read data is discarded. The next `frame_ready` restarts from address 0.
- Startup, with `frame_ready` sampled at cycle 0:
  - cycle 1: `bram_addr`=0 issued.
  - cycle 2: word 0 captured into the FIFO.
  - cycle 3: first `m_valid`, with `m_user`=1.
- Throughput: 1 pixel/cycle sustained with `m_ready` held high; one read per 8 cycles after the prefetch fill.
- Full frame, `m_ready`=1: last pixel accepted at cycle 3+8*`WORDS_PER_FRAME`-1. `frame_done` follows 1 cycle later, and `busy` is low on the cycle after that.
- The frame is complete after `WORDS_PER_FRAME` pops. The last pixel has `m_last`=1.

## Test plan
- Full frame, default params, `m_ready`=1, BRAM model returning addr-derived words:
  - required: 76800 beats, 240 `m_last`, exactly one `m_user` (on beat 0);
  - required: first `m_valid` at cycle 3, `frame_done` at cycle 76803.
- Byte order: word 0 = 0x0001020304050607, word 1 = 0x08090A0B0C0D0E0F.
  - required: first 16 pixels are 0x00..0x0F in order.
- Random `m_ready` (50% duty) over a full frame:
  - required: data sequence identical to the ready-high run;
  - required: outputs stable while stalled; never more than 2 words buffered or in flight;
  - required: `bram_addr` never exceeds 9599.
- `frame_ready` pulsed at pixel 1000 mid-frame:
  - required: one `overrun` pulse the next cycle; stream and `frame_done` timing unchanged.
- `rst` high for 1 cycle at pixel 500:
  - required: all outputs 0 the next cycle, no further beats;
  - required: a subsequent `frame_ready` restarts at addr 0 with `m_user`=1.
- `WORDS_PER_FRAME`=4, `WORDS_PER_LINE`=2, two back-to-back frames (second `frame_ready` one cycle after `frame_done`):
  - required: 32 beats per frame, `m_last` on beats 15 and 31;
  - required: no `overrun`, two `frame_done` pulses.
